// File: rtl/dmg_timer.sv
// DIV/TIMA/TMA/TAC timer mapped at FF04-FF07. TIMA ticks on falling edges of the
// selected divider bit. Overflow reloads from TMA after a 4-cycle delay with a one-cycle IRQ.
module dmg_timer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  din_i,
  input  logic        wr_i,
  input  logic        rd_i,
  output logic [7:0]  dout_o,
  output logic        sel_o,
  output logic        irq_req_o
);
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned DLY_W = 2;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } state_e;

  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    tima_q;
  logic [DW-1:0]    tma_q;
  logic [2:0]       tac_q;
  logic             sig_q;
  logic [DLY_W-1:0] dly_q;
  logic             irq_q;
  state_e           state_q;

  logic cnt_bit;
  logic sig;
  logic inc;
  logic wr_div;
  logic wr_tima;
  logic wr_tma;
  logic wr_tac;

  assign sel_o     = (addr_i[15:2] == ADDR_DIV[15:2]);
  assign irq_req_o = irq_q;

  assign wr_div  = wr_i && (addr_i == ADDR_DIV);
  assign wr_tima = wr_i && (addr_i == ADDR_TIMA);
  assign wr_tma  = wr_i && (addr_i == ADDR_TMA);
  assign wr_tac  = wr_i && (addr_i == ADDR_TAC);

  // Divider tap selected by TAC[1:0]
  always_comb begin
    cnt_bit = 1'b0;
    unique case (tac_q[1:0])
      2'b00: cnt_bit = cnt_q[9];
      2'b01: cnt_bit = cnt_q[3];
      2'b10: cnt_bit = cnt_q[5];
      2'b11: cnt_bit = cnt_q[7];
      default: cnt_bit = 1'b0;
    endcase
  end

  // Falling-edge detect: disabling or retargeting the tap while high also ticks
  assign sig = tac_q[2] & cnt_bit;
  assign inc = sig_q & ~sig;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      tima_q  <= '0;
      tma_q   <= '0;
      tac_q   <= '0;
      dly_q   <= '0;
      irq_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      cnt_q <= wr_div ? '0 : cnt_q + CNT_W'(1);
      sig_q <= sig;
      irq_q <= 1'b0;
      if (wr_tma) tma_q <= din_i;
      if (wr_tac) tac_q <= din_i[2:0];

      unique case (state_q)
        IDLE: begin
          if (wr_tima) begin
            tima_q <= din_i;
          end else if (inc) begin
            if (tima_q == 8'hFF) begin
              tima_q  <= '0;
              dly_q   <= DLY_W'(3);
              state_q <= OVF;
            end else begin
              tima_q <= tima_q + DW'(1);
            end
          end
        end
        OVF: begin
          if (wr_tima) begin
            tima_q  <= din_i;
            state_q <= IDLE;
          end else if (dly_q == '0) begin
            tima_q  <= tma_q;
            irq_q   <= 1'b1;
            state_q <= RELOAD;
          end else begin
            dly_q <= dly_q - DLY_W'(1);
            if (inc) tima_q <= tima_q + DW'(1);
          end
        end
        RELOAD: begin
          // TIMA writes are dropped here; a TMA write lands in both registers
          state_q <= IDLE;
          if (wr_tma)   tima_q <= din_i;
          else if (inc) tima_q <= tima_q + DW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dout_o = 8'hFF;
    if (rd_i && sel_o) begin
      unique case (addr_i[1:0])
        2'b00: dout_o = cnt_q[15:8];
        2'b01: dout_o = tima_q;
        2'b10: dout_o = tma_q;
        2'b11: dout_o = {5'b11111, tac_q};
        default: dout_o = 8'hFF;
      endcase
    end
  end
endmodule

// File: tb/tb_dmg_timer.sv
// Scoreboard bench for dmg_timer: the driver queues hand-computed expectations,
// and the negedge monitor pops and compares them on every read or probe cycle.
module tb_dmg_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        probe = 1'b0;
  logic        drain = 1'b0;
  logic [7:0]  dout;
  logic        sel;
  logic        irq;

  typedef struct packed {
    logic       pr;
    logic [7:0] d;
    logic       s;
    logic       q;
    logic [7:0] c;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    irq_cnt = 0;
  int    cyc = 0;
  int    base = 0;

  always #5 clk = ~clk;

  dmg_timer dut (
    .clk_i    (clk),
    .reset_i  (rst),
    .addr_i   (addr),
    .din_i    (din),
    .wr_i     (wr),
    .rd_i     (rd),
    .dout_o   (dout),
    .sel_o    (sel),
    .irq_req_o(irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts IRQ cycles and checks every read/probe against the queue
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (rst) irq_cnt = 0;
    else if (irq) irq_cnt = irq_cnt + 1;
    if (rd || probe) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL scoreboard_underflow: output seen with no expectation queued");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.pr) begin
          if (irq_cnt != int'(e.c)) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: irq pulses got %0d, expected %0d", nm, irq_cnt, e.c);
          end
        end else if (dout !== e.d || sel !== e.s || irq !== e.q) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got dout=%h sel=%b irq=%b, expected dout=%h sel=%b irq=%b",
                   nm, dout, sel, irq, e.d, e.s, e.q);
        end
      end
    end
    if (drain) begin
      n_cmp = n_cmp + 1;
      if (exp_q.size() != 0) begin
        n_bad = n_bad + 1;
        $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic goto_cyc(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] d, input logic q, input string nm);
    exp_t e;
    e.pr = 1'b0;
    e.d  = d;
    e.s  = (a >= 16'hFF04) && (a <= 16'hFF07);
    e.q  = q;
    e.c  = 8'h00;
    exp_q.push_back(e);
    name_q.push_back(nm);
    addr = a;
    rd   = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  task automatic probe_chk(input int n, input string nm);
    exp_t e;
    e.pr = 1'b1;
    e.d  = 8'h00;
    e.s  = 1'b0;
    e.q  = 1'b0;
    e.c  = 8'(n);
    exp_q.push_back(e);
    name_q.push_back(nm);
    probe = 1'b1;
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  // TMA=80, TIMA=FF, TAC=05: wrap at end of C16, OVF C17..C20, RELOAD C21
  task automatic ovf_setup();
    do_reset(2);
    wr_reg(16'hFF06, 8'h80);
    wr_reg(16'hFF05, 8'hFF);
    wr_reg(16'hFF07, 8'h05);
  endtask

  initial begin
    do_reset(8);
    rd_chk(16'hFF04, 8'h00, 1'b0, "rst_div");
    rd_chk(16'hFF05, 8'h00, 1'b0, "rst_tima");
    rd_chk(16'hFF06, 8'h00, 1'b0, "rst_tma");
    rd_chk(16'hFF07, 8'hF8, 1'b0, "rst_tac");
    rd_chk(16'hFF08, 8'hFF, 1'b0, "unsel_ff08");
    rd_chk(16'hFF03, 8'hFF, 1'b0, "unsel_ff03");
    probe_chk(0, "rst_irq_none");

    // 16-cycle tick period
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(16);
    rd_chk(16'hFF05, 8'h00, 1'b0, "tick16_before");
    rd_chk(16'hFF05, 8'h01, 1'b0, "tick16_first");
    goto_cyc(32);
    rd_chk(16'hFF05, 8'h01, 1'b0, "tick16_hold");
    rd_chk(16'hFF05, 8'h02, 1'b0, "tick16_second");
    goto_cyc(256);
    rd_chk(16'hFF05, 8'h0F, 1'b0, "tick16_0f");
    rd_chk(16'hFF05, 8'h10, 1'b0, "tick16_10");
    goto_cyc(600);
    rd_chk(16'hFF04, 8'h02, 1'b0, "div_at_600");

    // 256-cycle tick period
    do_reset(2);
    wr_reg(16'hFF07, 8'h07);
    goto_cyc(256);
    rd_chk(16'hFF05, 8'h00, 1'b0, "tick256_before");
    rd_chk(16'hFF05, 8'h01, 1'b0, "tick256_first");

    // Overflow and reload
    ovf_setup();
    goto_cyc(16);
    rd_chk(16'hFF05, 8'hFF, 1'b0, "ovf_pre");
    for (int i = 0; i < 4; i++) rd_chk(16'hFF05, 8'h00, 1'b0, "ovf_zero");
    rd_chk(16'hFF05, 8'h80, 1'b1, "ovf_reload_irq");
    rd_chk(16'hFF05, 8'h80, 1'b0, "ovf_after");
    rd_chk(16'hFF06, 8'h80, 1'b0, "ovf_tma");
    probe_chk(1, "ovf_irq_single");

    // TIMA write in second OVF cycle cancels reload
    ovf_setup();
    goto_cyc(17);
    rd_chk(16'hFF05, 8'h00, 1'b0, "cancel_ovf1");
    wr_reg(16'hFF05, 8'h33);
    rd_chk(16'hFF05, 8'h33, 1'b0, "cancel_val");
    goto_cyc(24);
    rd_chk(16'hFF05, 8'h33, 1'b0, "cancel_hold");
    probe_chk(0, "cancel_no_irq");

    // TMA write in RELOAD cycle lands in TIMA too
    ovf_setup();
    goto_cyc(21);
    wr_reg(16'hFF06, 8'hC0);
    rd_chk(16'hFF05, 8'hC0, 1'b0, "reload_tma_tima");
    rd_chk(16'hFF06, 8'hC0, 1'b0, "reload_tma_tma");
    probe_chk(1, "reload_tma_irq");

    // TIMA write in RELOAD cycle is ignored
    ovf_setup();
    goto_cyc(21);
    wr_reg(16'hFF05, 8'h11);
    rd_chk(16'hFF05, 8'h80, 1'b0, "reload_tima_ignored");
    probe_chk(1, "reload_tima_irq");

    // Reset during OVF aborts with no IRQ
    ovf_setup();
    goto_cyc(18);
    do_reset(2);
    goto_cyc(10);
    rd_chk(16'hFF05, 8'h00, 1'b0, "abort_tima");
    rd_chk(16'hFF07, 8'hF8, 1'b0, "abort_tac");
    probe_chk(0, "abort_no_irq");

    // TIMA write beats a coincident increment
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(16);
    wr_reg(16'hFF05, 8'h40);
    rd_chk(16'hFF05, 8'h40, 1'b0, "write_beats_inc");

    // DIV clear while CNT[3]=1 ticks TIMA
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(8);
    wr_reg(16'hFF04, 8'hAB);
    rd_chk(16'hFF05, 8'h00, 1'b0, "div_glitch_before");
    rd_chk(16'hFF05, 8'h01, 1'b0, "div_glitch_inc");
    rd_chk(16'hFF04, 8'h00, 1'b0, "div_cleared");

    // DIV clear while CNT[3]=0 does not tick
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(4);
    wr_reg(16'hFF04, 8'h00);
    rd_chk(16'hFF05, 8'h00, 1'b0, "div_noglitch_a");
    rd_chk(16'hFF05, 8'h00, 1'b0, "div_noglitch_b");

    // TAC disable while CNT[3]=1 ticks TIMA
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(8);
    wr_reg(16'hFF07, 8'h01);
    rd_chk(16'hFF05, 8'h00, 1'b0, "tac_glitch_before");
    rd_chk(16'hFF05, 8'h01, 1'b0, "tac_glitch_inc");
    rd_chk(16'hFF07, 8'hF9, 1'b0, "tac_readback");
    wr_reg(16'hFF07, 8'h02);
    rd_chk(16'hFF07, 8'hFA, 1'b0, "tac_upper_ignored");

    // TAC disable while CNT[3]=0 does not tick
    do_reset(2);
    wr_reg(16'hFF07, 8'h05);
    goto_cyc(4);
    wr_reg(16'hFF07, 8'h01);
    rd_chk(16'hFF05, 8'h00, 1'b0, "tac_noglitch_a");
    rd_chk(16'hFF05, 8'h00, 1'b0, "tac_noglitch_b");

    drain = 1'b1;
    @(posedge clk);
    #1;
    drain = 1'b0;
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
